// File: rtl/icache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// icache_refill_ctrl
//
// Instruction-cache refill sequencer in the CPU clock domain. When the I-cache
// misses, it sends one critical-word-first line request to the AXI read
// engine. It then pops the returning 64-bit beats from the read port of the
// cross-domain data FIFO. Each beat is written into the line fill buffer at
// its wrapped beat index, and the critical (first) beat is also forwarded to
// fetch. If fetch is redirected mid-refill, the rest of the burst is drained
// and discarded so the FIFO is left empty for the next refill.
//
// Ports
//   cpu_clk, cpu_reset           clock, asynchronous active-high reset
//   miss_valid_i/addr_i/ready_o  miss request handshake (byte address)
//   ar_valid_o/addr_o/ready_i    line request to the AXI read engine
//   fifo_rd_en_o/data_i/empty_i  show-ahead data FIFO read port
//   fill_we_o/idx_o/data_o       one beat write into the line fill buffer
//   fill_done_o                  last beat of the line (same cycle as fill_we_o)
//   fill_addr_o                  line-aligned address of the line being filled
//   crit_valid_o/data_o          one-cycle critical beat forward to fetch
//   flush_i                      fetch redirect, abandon current refill
//   busy_o                       refill in progress
// ---------------------------------------------------------------------------
module icache_refill_ctrl #(
  parameter int ADDR_W     = 39,
  parameter int LINE_BEATS = 8,
  localparam int IDX_W     = $clog2(LINE_BEATS)
) (
  input  logic              cpu_clk,
  input  logic              cpu_reset,
  input  logic              miss_valid_i,
  input  logic [ADDR_W-1:0] miss_addr_i,
  output logic              miss_ready_o,
  output logic              ar_valid_o,
  output logic [ADDR_W-1:0] ar_addr_o,
  input  logic              ar_ready_i,
  output logic              fifo_rd_en_o,
  input  logic [63:0]       fifo_rd_data_i,
  input  logic              fifo_rd_empty_i,
  output logic              fill_we_o,
  output logic [IDX_W-1:0]  fill_idx_o,
  output logic [63:0]       fill_data_o,
  output logic              fill_done_o,
  output logic [ADDR_W-1:0] fill_addr_o,
  output logic              crit_valid_o,
  output logic [63:0]       crit_data_o,
  input  logic              flush_i,
  output logic              busy_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  // Beat counter is one bit wider than the index so a full line is countable.
  localparam logic [IDX_W:0] LAST_CNT = (IDX_W+1)'(LINE_BEATS - 1);
  localparam logic [IDX_W:0] CNT_ONE  = (IDX_W+1)'(1);

  logic [1:0]        state_q, state_d;
  // Beat-granular address of the miss (byte offset within a beat dropped).
  logic [ADDR_W-4:0] addr_q, addr_d;
  logic [IDX_W:0]    cnt_q, cnt_d;
  logic              discard_q, discard_d;

  logic              fill_we_q, fill_we_d;
  logic [IDX_W-1:0]  fill_idx_q, fill_idx_d;
  logic [63:0]       fill_data_q, fill_data_d;
  logic              fill_done_q, fill_done_d;
  logic              crit_valid_q, crit_valid_d;
  logic [63:0]       crit_data_q, crit_data_d;

  logic [IDX_W-1:0]  crit_idx;
  logic              pop;
  logic              last_pop;

  // Byte offset within a beat is irrelevant to a line refill.
  logic              unused_addr_bits;
  assign unused_addr_bits = ^miss_addr_i[2:0];

  assign crit_idx = addr_q[IDX_W-1:0];

  // Combinational handshake outputs, all forced low while not in the owning state.
  assign miss_ready_o = (state_q == S_IDLE) & ~flush_i & ~cpu_reset;
  assign ar_valid_o   = (state_q == S_REQ);
  assign ar_addr_o    = {addr_q, 3'b000};
  assign fifo_rd_en_o = ((state_q == S_DATA) | (state_q == S_DRAIN)) & ~fifo_rd_empty_i;
  assign busy_o       = (state_q != S_IDLE);
  assign fill_addr_o  = {addr_q[ADDR_W-4:IDX_W], {(IDX_W+3){1'b0}}};

  assign pop      = fifo_rd_en_o;
  assign last_pop = pop & (cnt_q == LAST_CNT);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    discard_d    = discard_q;
    fill_we_d    = 1'b0;
    fill_done_d  = 1'b0;
    crit_valid_d = 1'b0;
    fill_idx_d   = fill_idx_q;
    fill_data_d  = fill_data_q;
    crit_data_d  = crit_data_q;

    case (state_q)
      S_IDLE: begin
        if (miss_valid_i && miss_ready_o) begin
          addr_d    = miss_addr_i[ADDR_W-1:3];
          cnt_d     = '0;
          discard_d = 1'b0;
          state_d   = S_REQ;
        end
      end

      S_REQ: begin
        // The request cannot be withdrawn once raised; a redirect only
        // marks the burst for discard.
        if (flush_i) begin
          discard_d = 1'b1;
        end
        if (ar_ready_i) begin
          state_d = (discard_q || flush_i) ? S_DRAIN : S_DATA;
        end
      end

      S_DATA: begin
        if (pop) begin
          cnt_d = cnt_q + CNT_ONE;
          if (!flush_i) begin
            fill_we_d   = 1'b1;
            // Critical-word-first order: index wraps modulo the line.
            fill_idx_d  = crit_idx + cnt_q[IDX_W-1:0];
            fill_data_d = fifo_rd_data_i;
            if (cnt_q == '0) begin
              crit_valid_d = 1'b1;
              crit_data_d  = fifo_rd_data_i;
            end
            if (last_pop) begin
              fill_done_d = 1'b1;
              state_d     = S_IDLE;
            end
          end
        end
        // A beat popped in the flush cycle still counts toward the burst.
        if (flush_i) begin
          state_d = last_pop ? S_IDLE : S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (pop) begin
          cnt_d = cnt_q + CNT_ONE;
          if (last_pop) begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge cpu_clk or posedge cpu_reset) begin
    if (cpu_reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      cnt_q        <= '0;
      discard_q    <= 1'b0;
      fill_we_q    <= 1'b0;
      fill_idx_q   <= '0;
      fill_data_q  <= '0;
      fill_done_q  <= 1'b0;
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      discard_q    <= discard_d;
      fill_we_q    <= fill_we_d;
      fill_idx_q   <= fill_idx_d;
      fill_data_q  <= fill_data_d;
      fill_done_q  <= fill_done_d;
      crit_valid_q <= crit_valid_d;
      crit_data_q  <= crit_data_d;
    end
  end

  assign fill_we_o    = fill_we_q;
  assign fill_idx_o   = fill_idx_q;
  assign fill_data_o  = fill_data_q;
  assign fill_done_o  = fill_done_q;
  assign crit_valid_o = crit_valid_q;
  assign crit_data_o  = crit_data_q;

endmodule
